// File: rtl/mdio_pkg.sv
`timescale 1ns/1ps
// Shared constants, frame layout and state encoding for the Clause-22 MDIO master.
package mdio_pkg;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;

    localparam int unsigned HEADER_BITS = 14;
    localparam int unsigned TA_BITS     = 2;
    localparam int unsigned DATA_BITS   = 16;
    localparam int unsigned FRAME_W     = 32;
    localparam int unsigned CNT_W       = 7;

    // Everything after the preamble, shifted out MSB first.
    typedef struct packed {
        logic [1:0]           st;
        logic [1:0]           op;
        logic [4:0]           phyad;
        logic [4:0]           regad;
        logic [1:0]           ta;
        logic [DATA_BITS-1:0] data;
    } mdio_frame_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        HEADER   = 3'd2,
        TA       = 3'd3,
        DATA     = 3'd4,
        TAIL     = 3'd5
    } state_t;

endpackage

// File: rtl/mdio_master.sv
`timescale 1ns/1ps
// Clause-22 MDIO master: runs one read or write frame per accepted request.
// Ports:
//   clock, reset_n       system clock (MDC = clock/2), async active-low reset
//   addr                 REGAD, sampled at acceptance
//   rd_request/wr_request start a frame while ready=1 (write wins if both)
//   wr_data              write data, sampled at acceptance
//   ready                1 = idle, can accept; rd_data valid while high
//   rd_data              last read result
//   mdio_pin             bidirectional MDIO, released (Z) when not driving
//   mdc_pin              MDC, low whenever idle
module mdio_master
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR      = 5'b00000,
    parameter int unsigned PREAMBLE_BITS = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [4:0]           addr,
    input  logic                 rd_request,
    input  logic                 wr_request,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 ready,
    output logic [DATA_BITS-1:0] rd_data,
    inout  wire                  mdio_pin,
    output logic                 mdc_pin
);

    // Bit index at which each section of the frame begins.
    localparam logic [CNT_W-1:0] HDR_START  = CNT_W'(PREAMBLE_BITS);
    localparam logic [CNT_W-1:0] TA_START   = CNT_W'(PREAMBLE_BITS + HEADER_BITS);
    localparam logic [CNT_W-1:0] DATA_START = CNT_W'(PREAMBLE_BITS + HEADER_BITS + TA_BITS);
    localparam logic [CNT_W-1:0] TAIL_START = CNT_W'(PREAMBLE_BITS + HEADER_BITS + TA_BITS + DATA_BITS);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, nxt_cnt;
    logic                 phase_q, phase_d;
    logic [FRAME_W-1:0]   tx_q, tx_d;
    logic [DATA_BITS-1:0] rx_q, rx_d;
    logic                 is_rd_q, is_rd_d;
    logic                 mdc_q, mdc_d;
    logic                 dout_q, dout_d;
    logic                 oe_q, oe_d;
    logic                 ready_q, ready_d;
    logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
    mdio_frame_t          load_frame;

    // Frame image captured on acceptance; the TA field is only driven on writes.
    assign load_frame = '{
        st:    MDIO_ST,
        op:    wr_request ? MDIO_OP_WR : MDIO_OP_RD,
        phyad: PHY_ADDR,
        regad: addr,
        ta:    MDIO_TA_WR,
        data:  wr_data
    };

    assign nxt_cnt = cnt_q + CNT_W'(1);

    // State register and all pin-facing outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            is_rd_q   <= 1'b0;
            mdc_q     <= 1'b0;
            dout_q    <= 1'b1;
            oe_q      <= 1'b0;
            ready_q   <= 1'b1;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            is_rd_q   <= is_rd_d;
            mdc_q     <= mdc_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            ready_q   <= ready_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Next state: phase 0 raises MDC; end of phase 1 samples, advances and sets up the next bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        is_rd_d   = is_rd_q;
        mdc_d     = 1'b0;
        dout_d    = dout_q;
        oe_d      = oe_q;
        ready_d   = ready_q;
        rd_data_d = rd_data_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                oe_d    = 1'b0;
                dout_d  = 1'b1;
                cnt_d   = '0;
                phase_d = 1'b0;
                if (rd_request || wr_request) begin
                    is_rd_d = !wr_request;
                    tx_d    = load_frame;
                    state_d = PREAMBLE;
                    ready_d = 1'b0;
                    oe_d    = 1'b1;
                    dout_d  = 1'b1;
                end
            end

            PREAMBLE, HEADER, TA, DATA, TAIL: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    mdc_d   = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    cnt_d   = nxt_cnt;
                    // One full clock after MDC rose: covers the PHY output delay.
                    if (state_q == DATA) begin
                        rx_d = {rx_q[DATA_BITS-2:0], mdio_pin};
                    end
                    if (state_q == TAIL) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        if (is_rd_q) begin
                            rd_data_d = rx_q;
                        end
                    end else if (nxt_cnt < HDR_START) begin
                        state_d = PREAMBLE;
                        oe_d    = 1'b1;
                        dout_d  = 1'b1;
                    end else if (nxt_cnt < TAIL_START) begin
                        if (nxt_cnt < TA_START) begin
                            state_d = HEADER;
                        end else if (nxt_cnt < DATA_START) begin
                            state_d = TA;
                        end else begin
                            state_d = DATA;
                        end
                        // Reads hand the bus to the PHY from the first TA bit.
                        oe_d   = (nxt_cnt < TA_START) || !is_rd_q;
                        dout_d = tx_q[FRAME_W-1];
                        tx_d   = tx_q << 1;
                    end else begin
                        state_d = TAIL;
                        oe_d    = 1'b0;
                        dout_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                oe_d    = 1'b0;
                cnt_d   = '0;
                phase_d = 1'b0;
            end
        endcase
    end

    assign ready    = ready_q;
    assign rd_data  = rd_data_q;
    assign mdc_pin  = mdc_q;
    assign mdio_pin = oe_q ? dout_q : 1'bz;

endmodule

// File: tb/tb_mdio_master.sv
`timescale 1ns/1ps
// Bench for mdio_master: PHY model on MDIO, frame monitor and expected-frame scoreboard.
module tb_mdio_master;

    localparam int unsigned FRAME_CLKS = 130;
    localparam int unsigned FRAME_BITS = 65;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [4:0]  addr = '0;
    logic        rd_request = 1'b0;
    logic        wr_request = 1'b0;
    logic [15:0] wr_data = '0;
    logic        ready;
    logic [15:0] rd_data;
    logic        mdc_pin;
    wire         mdio;

    pullup (mdio);

    // PHY side of MDIO
    logic        phy_oe = 1'b0;
    logic        phy_d = 1'b1;
    logic        phy_read = 1'b0;
    logic [15:0] phy_data = '0;
    assign mdio = phy_oe ? phy_d : 1'bz;

    mdio_master #(.PHY_ADDR(5'b00000), .PREAMBLE_BITS(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .addr       (addr),
        .rd_request (rd_request),
        .wr_request (wr_request),
        .wr_data    (wr_data),
        .ready      (ready),
        .rd_data    (rd_data),
        .mdio_pin   (mdio),
        .mdc_pin    (mdc_pin)
    );

    always #200 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [64:0] bits;
        logic [15:0] rd;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [15:0] phy;
        logic [15:0] exp_rd;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bits seen on MDIO at each MDC rise. TA on reads: pull-up then PHY-driven 0.
    function automatic logic [64:0] exp_bits(input logic rd, input logic [4:0] a, input logic [15:0] d);
        return {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), 5'b00000, a, 2'b10, d, 1'b1};
    endfunction

    // Capture + PHY model, keyed to MDC rises within the current frame.
    int          frame_id = 0;
    int          cap_id = 0;
    int          ncap = 0;
    logic [64:0] cap = '0;

    always @(posedge mdc_pin) begin
        int k;
        if (cap_id != frame_id) begin
            cap_id = frame_id;
            ncap   = 0;
            cap    = '0;
        end
        k = ncap;
        #300;
        if (phy_read && k == 47) begin
            phy_oe = 1'b1;
            phy_d  = 1'b0;
        end else if (phy_read && k >= 48 && k <= 63) begin
            phy_oe = 1'b1;
            phy_d  = phy_data[4'(63 - k)];
        end else begin
            phy_oe = 1'b0;
        end
        #50;
        cap = {cap[63:0], mdio};
        ncap++;
    end

    // Frame monitor: measures ready-low time and compares each finished frame.
    logic prev_ready = 1'b1;
    logic in_frame = 1'b0;
    int   low_cnt = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_ready = 1'b1;
            in_frame   = 1'b0;
        end else begin
            if (!ready) begin
                if (prev_ready) begin
                    frame_id++;
                    in_frame = 1'b1;
                    low_cnt  = 0;
                end
                low_cnt++;
            end else if (!prev_ready && in_frame) begin
                exp_t e;
                in_frame = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got frame %0d expected none", frame_id);
                end else begin
                    e = sb.pop_front();
                    check("frame_bits", cap, e.bits);
                    check("frame_len", 65'(ncap), 65'(FRAME_BITS));
                    check("ready_low_clks", 65'(low_cnt), 65'(FRAME_CLKS));
                    check("rd_data", 65'(rd_data), 65'(e.rd));
                end
            end
            prev_ready = ready;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=%b expected 1", ready);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || !ready) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0 || !ready) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got pending=%0d ready=%b expected 0 and 1", sb.size(), ready);
        end
    endtask

    // Present a request at a negedge, hold it until ready falls, then drop it.
    task automatic issue(input logic rd, input logic wr, input logic [4:0] a, input logic [15:0] wd,
                         input logic [15:0] ph, input logic [15:0] exp_rd, input bit push);
        exp_t e;
        int   n = 0;
        wait_ready();
        @(negedge clock);
        rd_request = rd;
        wr_request = wr;
        addr       = a;
        wr_data    = wd;
        phy_data   = ph;
        phy_read   = rd && !wr;
        if (push) begin
            e.bits = exp_bits(rd && !wr, a, (rd && !wr) ? ph : wd);
            e.rd   = exp_rd;
            sb.push_back(e);
        end
        do begin
            @(negedge clock);
            n++;
        end while (ready && n < 8);
        check("accept", 65'(ready), 65'(0));
        rd_request = 1'b0;
        wr_request = 1'b0;
    endtask

    initial begin
        #(5ms);
        $display("FAIL watchdog: got no finish expected finish within 5 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_t e;

        vecs[0] = '{rd: 1'b0, wr: 1'b1, addr: 5'd9,  wdata: 16'h0200, phy: 16'h0000, exp_rd: 16'h0000};
        vecs[1] = '{rd: 1'b1, wr: 1'b1, addr: 5'd0,  wdata: 16'h1300, phy: 16'hFFFF, exp_rd: 16'h0000};
        vecs[2] = '{rd: 1'b1, wr: 1'b0, addr: 5'd31, wdata: 16'h0000, phy: 16'hA5C3, exp_rd: 16'hA5C3};
        vecs[3] = '{rd: 1'b0, wr: 1'b1, addr: 5'd21, wdata: 16'hBEEF, phy: 16'h0000, exp_rd: 16'hA5C3};
        vecs[4] = '{rd: 1'b1, wr: 1'b0, addr: 5'd3,  wdata: 16'h7777, phy: 16'h0001, exp_rd: 16'h0001};

        // Power-on reset
        #10 reset_n = 1'b0;
        #1;
        check("rst_ready", 65'(ready), 65'(1));
        check("rst_rd_data", 65'(rd_data), 65'(0));
        check("rst_mdc", 65'(mdc_pin), 65'(0));
        check("rst_mdio_released", 65'(mdio), 65'(1));
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Reset in the middle of a read frame
        issue(1'b1, 1'b0, 5'd7, 16'h0000, 16'h1234, 16'h0000, 1'b0);
        repeat (69) @(negedge clock);
        #50 reset_n = 1'b0;
        #1;
        check("midrst_ready", 65'(ready), 65'(1));
        check("midrst_mdc", 65'(mdc_pin), 65'(0));
        check("midrst_mdio_released", 65'(mdio), 65'(1));
        check("midrst_rd_data", 65'(rd_data), 65'(0));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        issue(1'b0, 1'b1, 5'd2, 16'hC33C, 16'h0000, 16'h0000, 1'b1);
        wait_done();

        // Read request pulsed during clock 60 of a write is dropped
        issue(1'b0, 1'b1, 5'd5, 16'h5A5A, 16'h0000, 16'h0000, 1'b1);
        repeat (59) @(negedge clock);
        rd_request = 1'b1;
        @(negedge clock);
        rd_request = 1'b0;
        wait_done();
        n = frame_id;
        repeat (4) @(negedge clock);
        check("ignored_no_frame", 65'(frame_id - n), 65'(0));
        check("ignored_ready", 65'(ready), 65'(1));

        // Vector table
        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].phy, vecs[i].exp_rd, 1'b1);
            wait_done();
        end

        // rd_request held high: back-to-back reads with one idle clock between
        wait_ready();
        @(negedge clock);
        addr       = 5'd17;
        phy_data   = 16'h3C96;
        phy_read   = 1'b1;
        rd_request = 1'b1;
        e.bits     = exp_bits(1'b1, 5'd17, 16'h3C96);
        e.rd       = 16'h3C96;
        sb.push_back(e);
        sb.push_back(e);
        n = 0;
        while (ready && n < 8) begin
            @(negedge clock);
            n++;
        end
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        n = 0;
        while (ready && n < 10) begin
            n++;
            @(negedge clock);
        end
        check("b2b_idle_clks", 65'(n), 65'(1));
        rd_request = 1'b0;
        wait_done();
        check("b2b_rd_data", 65'(rd_data), 65'(16'h3C96));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
